i2c_temp_poll_scheduler: RTL and testbench

Sequencer that sits above the I2C temperature-read controller and decides when a read runs. It merges a free-running periodic poll and a user request into one read at a time, and drives the controller's Start/Done handshake with a timeout. On completion it latches the 16-bit result from the shift datapath. It publishes raw and whole-degree temperature with a one-cycle Valid strobe, for display and UART blocks.

---
 rtl/i2c_temp_poll_scheduler.sv | 145 ++++++++++++++
 tb/tb_i2c_temp_poll_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_temp_poll_scheduler.sv
// Schedules reads on the I2C temperature controller: merges periodic ticks and manual
// requests, drives the Start/Done handshake with a timeout, and publishes the result.
module i2c_temp_poll_scheduler #(
  parameter int unsigned POLL_PERIOD = 50000000,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        ReqRead,
  input  logic        ClearError,
  input  logic        Done,
  input  logic [15:0] RawTemp,
  output logic        Start,
  output logic        Busy,
  output logic        Valid,
  output logic [12:0] TempRaw,
  output logic [8:0]  TempInt,
  output logic [7:0]  SampleCount,
  output logic        Error
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              pend_man_q, pend_man_d;
  logic              pend_per_q, pend_per_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [12:0]       temp_raw_q, temp_raw_d;
  logic [7:0]        sample_cnt_q, sample_cnt_d;
  logic              error_q, error_d;

  logic              tick;
  logic              issue;
  logic              timeout;
  logic              unused_raw_lsbs;

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    temp_raw_d   = temp_raw_q;
    sample_cnt_d = sample_cnt_q;
    valid_d      = 1'b0;
    issue        = 1'b0;
    timeout      = 1'b0;

    tick = Enable && (per_cnt_q == PER_LAST);
    if (!Enable || tick) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_man_q || pend_per_q) begin
          issue     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Done takes priority over a coincident timeout.
        if (Done) begin
          temp_raw_d   = RawTemp[15:3];
          sample_cnt_d = sample_cnt_q + 8'd1;
          valid_d      = 1'b1;
          state_d      = ST_RELEASE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout = 1'b1;
          state_d = ST_RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!Done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A request landing on the issue edge re-arms its flag rather than being absorbed.
    pend_man_d = (pend_man_q && !issue) || ReqRead;
    pend_per_d = (pend_per_q && !issue) || tick;
    error_d    = timeout || (error_q && !ClearError);
    start_d    = (state_d == ST_WAIT);
    busy_d     = (state_d != ST_IDLE);
  end

  always_comb begin
    unused_raw_lsbs = ^RawTemp[2:0];
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      per_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      pend_man_q   <= 1'b0;
      pend_per_q   <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      temp_raw_q   <= '0;
      sample_cnt_q <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      pend_man_q   <= pend_man_d;
      pend_per_q   <= pend_per_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      temp_raw_q   <= temp_raw_d;
      sample_cnt_q <= sample_cnt_d;
      error_q      <= error_d;
    end
  end

  assign Start       = start_q;
  assign Busy        = busy_q;
  assign Valid       = valid_q;
  assign TempRaw     = temp_raw_q;
  assign TempInt     = temp_raw_q[12:4];
  assign SampleCount = sample_cnt_q;
  assign Error       = error_q;

endmodule

// File: tb/tb_i2c_temp_poll_scheduler.sv
// Bench for i2c_temp_poll_scheduler: directed scenarios plus random traffic, with a
// transaction-level reference model and a simple read-controller model driving Done.
module tb_i2c_temp_poll_scheduler;

  localparam int unsigned P = 100;
  localparam int unsigned T = 50;

  logic        clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        ReqRead = 1'b0;
  logic        ClearError = 1'b0;
  logic        Done = 1'b0;
  logic [15:0] RawTemp = '0;
  logic        Start, Busy, Valid, Error;
  logic [12:0] TempRaw;
  logic [8:0]  TempInt;
  logic [7:0]  SampleCount;

  i2c_temp_poll_scheduler #(
    .POLL_PERIOD(P),
    .TIMEOUT    (T),
    .CNT_W      (8)
  ) dut (
    .clock      (clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .ReqRead    (ReqRead),
    .ClearError (ClearError),
    .Done       (Done),
    .RawTemp    (RawTemp),
    .Start      (Start),
    .Busy       (Busy),
    .Valid      (Valid),
    .TempRaw    (TempRaw),
    .TempInt    (TempInt),
    .SampleCount(SampleCount),
    .Error      (Error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one read in flight at a time, pending requests as booleans.
  int       m_per = 0;
  bit       m_pm = 0, m_pp = 0, m_reading = 0, m_draining = 0, m_valid = 0, m_err = 0;
  int       m_elapsed = 0;
  bit [12:0] m_raw = '0;
  int       m_cnt = 0;

  task automatic model_step();
    bit tick, issue, tmo;
    if (Reset) begin
      m_per = 0; m_pm = 0; m_pp = 0; m_reading = 0; m_draining = 0;
      m_valid = 0; m_err = 0; m_elapsed = 0; m_raw = '0; m_cnt = 0;
      return;
    end
    tick  = Enable && (m_per == P - 1);
    m_per = Enable ? (m_per + 1) % P : 0;
    issue = 0;
    tmo   = 0;
    m_valid = 0;
    if (m_reading) begin
      if (Done) begin
        m_raw = RawTemp[15:3];
        m_cnt = (m_cnt + 1) % 256;
        m_valid = 1;
        m_reading = 0;
        m_draining = 1;
      end else if (m_elapsed == T - 1) begin
        tmo = 1;
        m_reading = 0;
        m_draining = 1;
      end else begin
        m_elapsed++;
      end
    end else if (m_draining) begin
      if (!Done) m_draining = 0;
    end else if (m_pm || m_pp) begin
      issue = 1;
      m_reading = 1;
      m_elapsed = 0;
    end
    if (issue) begin
      m_pm = 0;
      m_pp = 0;
    end
    if (ReqRead) m_pm = 1;
    if (tick) m_pp = 1;
    if (tmo) m_err = 1;
    else if (ClearError) m_err = 0;
  endtask

  function automatic logic [33:0] exp_vec();
    logic [7:0] c;
    c = 8'(m_cnt);
    return {m_reading, m_reading | m_draining, m_valid, m_raw, m_raw[12:4], c, m_err};
  endfunction

  // Read-controller model: Done after ctl_lat cycles of Start (0 = never), held ctl_hold extra.
  int ctl_lat = 10, ctl_hold = 0, ctl_age = 0, ctl_hold_left = 0;

  int cyc = 0, run_len = 0, last_run = 0, valid_total = 0, last_valid_cyc = -1, valid_gap = 0;

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check_eq("outs", {Start, Busy, Valid, TempRaw, TempInt, SampleCount, Error}, exp_vec());
    cyc++;
    if (Start) run_len++;
    else if (run_len != 0) begin
      last_run = run_len;
      run_len = 0;
    end
    if (Valid) begin
      valid_total++;
      if (last_valid_cyc >= 0) valid_gap = cyc - last_valid_cyc;
      last_valid_cyc = cyc;
    end
    @(negedge clock);
    ReqRead = 1'b0;
    ClearError = 1'b0;
    Reset = 1'b0;
    if (Start) begin
      ctl_age++;
      if (ctl_age == 1) ctl_hold_left = ctl_hold;
      if (ctl_lat != 0 && ctl_age >= ctl_lat) Done = 1'b1;
    end else begin
      ctl_age = 0;
      if (Done) begin
        if (ctl_hold_left > 0) ctl_hold_left--;
        else Done = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int v0;

  initial begin
    // Reset
    Reset = 1'b1;
    @(negedge clock);
    Reset = 1'b1;
    step();
    Reset = 1'b1;
    step();
    check_eq("reset_outs", {Start, Busy, Valid, TempRaw, TempInt, SampleCount, Error}, 34'h0);

    // Periodic polling
    RawTemp = 16'h0C80; ctl_lat = 10; ctl_hold = 0;
    Enable = 1'b1;
    v0 = valid_total;
    run(450);
    check_eq("per_valids", 64'(valid_total - v0), 64'd4);
    check_eq("per_gap", 64'(valid_gap), 64'(P));
    check_eq("per_raw", TempRaw, 13'h0190);
    check_eq("per_int", TempInt, 9'd25);
    check_eq("per_count", SampleCount, 8'd4);
    Enable = 1'b0;
    run(20);

    // Negative value
    RawTemp = 16'hFFF8;
    ReqRead = 1'b1;
    run(30);
    check_eq("neg_raw", TempRaw, 13'h1FFF);
    check_eq("neg_int", TempInt, 9'h1FF);

    // Timeout
    ctl_lat = 0;
    v0 = valid_total;
    RawTemp = 16'h1234;
    ReqRead = 1'b1;
    run(70);
    check_eq("tmo_start_len", 64'(last_run), 64'(T));
    check_eq("tmo_error", Error, 1'b1);
    check_eq("tmo_no_valid", 64'(valid_total - v0), 64'd0);
    check_eq("tmo_raw_kept", TempRaw, 13'h1FFF);
    check_eq("tmo_count_kept", SampleCount, 8'd5);
    check_eq("tmo_idle", Busy, 1'b0);
    ClearError = 1'b1;
    run(2);
    check_eq("clear_error", Error, 1'b0);

    // Collapse: three requests during one busy read -> one more read
    ctl_lat = 10;
    v0 = valid_total;
    ReqRead = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 3 || i == 5 || i == 7) ReqRead = 1'b1;
      step();
    end
    check_eq("collapse_reads", 64'(valid_total - v0), 64'd2);

    // Merge: tick coincident with ReqRead -> single read
    Enable = 1'b1;
    for (int i = 0; i < 200 && m_per != P - 1; i++) step();
    check_eq("merge_aligned", 64'(m_per), 64'(P - 1));
    v0 = valid_total;
    ReqRead = 1'b1;
    run(60);
    check_eq("merge_reads", 64'(valid_total - v0), 64'd1);
    Enable = 1'b0;
    run(5);

    // Done held after Start drops, with a request queued meanwhile
    ctl_lat = 4; ctl_hold = 5;
    v0 = valid_total;
    ReqRead = 1'b1;
    run(3);
    ReqRead = 1'b1;
    run(40);
    check_eq("hold_reads", 64'(valid_total - v0), 64'd2);
    ctl_hold = 0;

    // Done and timeout in the same cycle
    ctl_lat = T;
    v0 = valid_total;
    ReqRead = 1'b1;
    run(70);
    check_eq("tie_valid", 64'(valid_total - v0), 64'd1);
    check_eq("tie_error", Error, 1'b0);
    check_eq("tie_start_len", 64'(last_run), 64'(T));

    // Reset mid-WAIT
    ctl_lat = 10;
    ReqRead = 1'b1;
    run(5);
    Reset = 1'b1;
    step();
    check_eq("rst_mid_outs", {Start, Busy, Valid, TempRaw, TempInt, SampleCount, Error}, 34'h0);
    Enable = 1'b1;
    run(120);
    Enable = 1'b0;
    run(20);

    // Randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      ctl_lat  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 60));
      ctl_hold = int'($urandom_range(0, 6));
      for (int i = 0; i < 200; i++) begin
        ReqRead    = ($urandom_range(0, 15) == 0);
        ClearError = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 63) == 0) Enable = ~Enable;
        if ($urandom_range(0, 499) == 0) Reset = 1'b1;
        if (!Done) RawTemp = 16'($urandom);
        step();
      end
    end

    // SampleCount wrap after 256 successful reads
    Enable = 1'b0;
    ctl_lat = 1; ctl_hold = 0;
    Reset = 1'b1;
    step();
    run(10);
    v0 = valid_total;
    for (int i = 0; i < 3000 && (valid_total - v0) < 256; i++) begin
      ReqRead = 1'b1;
      step();
    end
    check_eq("wrap_reads", 64'(valid_total - v0), 64'd256);
    check_eq("wrap_count", SampleCount, 8'd0);
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
